// File: rtl/ser_pkg.sv
// ---------------------------------------------------------------------------
// ser_pkg
// Shared types and constants for the byte line serializer.
//   t_byte      : one payload byte
//   t_ser_state : framing FSM states
//   IDLE_LEVEL  : level of the serial line when nothing is being sent
//   FRAME_BITS  : line cycles per frame (start + 8 data + stop)
// ---------------------------------------------------------------------------
package ser_pkg;

    typedef logic [7:0] t_byte;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } t_ser_state;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   FRAME_BITS = 10;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with show-ahead read: pop_data always presents the oldest
// entry, and pop advances past it at the clock edge.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push       : write push_data at the edge (ignored when full)
//   push_data  : entry to write
//   pop        : discard the head entry at the edge (ignored when empty)
//   pop_data   : head entry (undefined while empty)
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module sync_fifo
    import ser_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = t_byte
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     pop_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the
    // address bits match.
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    T            mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    // Storage carries no reset; only the pointers define occupancy.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/byte_line_serializer.sv
// ---------------------------------------------------------------------------
// byte_line_serializer
// Accepts bytes on a valid/ready stream, buffers them in a small FIFO and
// frames each one onto a single-bit line as start(0) / 8 data / stop(1).
// A stall input freezes the line on its current bit.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_data    : byte to send
//   in_valid   : in_data valid
//   in_ready   : FIFO can accept (not full)
//   ser_one    : registered serial line, idles high
//   ser_two    : stall request, 1 = hold current bit
//   busy       : frame in progress or bytes pending
//   frame_cnt  : completed frames, wraps
// ---------------------------------------------------------------------------
module byte_line_serializer
    import ser_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  t_byte            in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_one,
    input  logic             ser_two,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    t_ser_state       state_reg;
    t_byte            shift_reg;
    logic [2:0]       bit_idx_reg;
    logic             ser_one_reg;
    logic [CNT_W-1:0] frame_cnt_reg;

    logic  fifo_full;
    logic  fifo_empty;
    logic  fifo_pop;
    t_byte fifo_head;

    // Bit that leaves the shift register next, and the register after it
    // has been consumed.
    function automatic logic next_bit(input t_byte b);
        return MSB_FIRST ? b[7] : b[0];
    endfunction

    function automatic t_byte shift_out(input t_byte b);
        return MSB_FIRST ? {b[6:0], 1'b0} : {1'b0, b[7:1]};
    endfunction

    // The FSM loads a byte only from IDLE or at the end of STOP, and only on
    // an unstalled edge; this must match the load branches below.
    assign fifo_pop = !ser_two && !fifo_empty &&
                      ((state_reg == IDLE) || (state_reg == STOP));

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (t_byte)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            bit_idx_reg   <= '0;
            ser_one_reg   <= IDLE_LEVEL;
            frame_cnt_reg <= '0;
        end else if (!ser_two) begin
            case (state_reg)
                IDLE: begin
                    ser_one_reg <= IDLE_LEVEL;
                    if (!fifo_empty) begin
                        shift_reg   <= fifo_head;
                        ser_one_reg <= ~IDLE_LEVEL;
                        state_reg   <= START;
                    end
                end
                START: begin
                    ser_one_reg <= next_bit(shift_reg);
                    shift_reg   <= shift_out(shift_reg);
                    bit_idx_reg <= '0;
                    state_reg   <= DATA;
                end
                DATA: begin
                    if (bit_idx_reg == 3'd7) begin
                        ser_one_reg <= IDLE_LEVEL;   // stop bit
                        bit_idx_reg <= '0;
                        state_reg   <= STOP;
                    end else begin
                        ser_one_reg <= next_bit(shift_reg);
                        shift_reg   <= shift_out(shift_reg);
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                    end
                end
                STOP: begin
                    frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
                    if (!fifo_empty) begin
                        // Back-to-back: start bit follows the stop bit directly.
                        shift_reg   <= fifo_head;
                        ser_one_reg <= ~IDLE_LEVEL;
                        state_reg   <= START;
                    end else begin
                        ser_one_reg <= IDLE_LEVEL;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    ser_one_reg <= IDLE_LEVEL;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = !fifo_full;
    assign ser_one   = ser_one_reg;
    assign busy      = (state_reg != IDLE) || !fifo_empty;
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_byte_line_serializer.sv
// ---------------------------------------------------------------------------
// tb_byte_line_serializer
// Stimulus pushes bytes and records the expected frame (byte, line cycles)
// in a queue; a negedge monitor decodes frames off ser_one and compares them
// against the queue head. Directed checks cover exact bit timing, reset,
// back-pressure and counter wrap (frame_cnt is 4 bits wide here).
// ---------------------------------------------------------------------------
module tb_byte_line_serializer;
    import ser_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    typedef struct {
        logic [7:0] b;
        int         len;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             ser_one;
    logic             ser_two = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    byte_line_serializer #(
        .DEPTH     (DEPTH),
        .MSB_FIRST (1'b1),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_one   (ser_one),
        .ser_two   (ser_two),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // k-th line bit of an MSB-first frame of byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[8-k];
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push(input logic [7:0] b, input int len);
        int   n;
        exp_t e;
        n        = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: byte %02h in_ready %0b required 1", b, in_ready);
        end
        e.b   = b;
        e.len = len;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic       mon_active = 1'b0;
    int         mon_pos = 0;
    int         mon_cyc = 0;
    logic [7:0] mon_rx = '0;
    logic       mon_prev_stall = 1'b0;
    logic       mon_prev_level = 1'b1;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            mon_active     = 1'b0;
            mon_prev_stall = 1'b0;
            mon_prev_level = 1'b1;
        end else begin
            if (!mon_active && ser_one == 1'b0) begin
                mon_active = 1'b1;
                mon_pos    = 0;
                mon_cyc    = 0;
                mon_rx     = '0;
            end
            if (mon_active) begin
                mon_cyc++;
                if (mon_prev_stall && mon_cyc > 1)
                    chk("stall_hold", {31'd0, ser_one}, {31'd0, mon_prev_level});
                if (!ser_two) begin
                    if (mon_pos >= 1 && mon_pos <= 8) begin
                        mon_rx = {mon_rx[6:0], ser_one};
                    end else if (mon_pos == 9) begin
                        chk("stop_bit", {31'd0, ser_one}, 32'd1);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame: got %02h required none", mon_rx);
                        end else begin
                            e = exp_q.pop_front();
                            $display("frame %02h cycles %0d (expected %02h cycles %0d)",
                                     mon_rx, mon_cyc, e.b, e.len);
                            chk("frame_byte", {24'd0, mon_rx}, {24'd0, e.b});
                            chk("frame_len", mon_cyc, e.len);
                        end
                        mon_active = 1'b0;
                    end
                    mon_pos++;
                end
            end
            mon_prev_stall = ser_two;
            mon_prev_level = ser_one;
        end
    end

    // ---------------- stimulus ----------------
    logic [9:0] a5_bits = 10'b0101001011;  // bit 9 is the first line bit

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ser_one", {31'd0, ser_one}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_cnt", {28'd0, frame_cnt}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: single byte, exact line waveform and latency
        push(8'hA5, FRAME_BITS);
        @(negedge clk);
        chk("latency_idle", {31'd0, ser_one}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("a5_bit%0d", k), {31'd0, ser_one}, {31'd0, a5_bits[9-k]});
        end
        @(negedge clk);
        chk("a5_busy", {31'd0, busy}, 32'd0);
        chk("a5_frame_cnt", {28'd0, frame_cnt}, 32'd1);
        @(posedge clk);
        #1;

        // 2: back-to-back frames with no idle gap
        push(8'h3C, FRAME_BITS);
        push(8'hC3, FRAME_BITS);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_bit%0d", k), {31'd0, ser_one},
                {31'd0, frame_bit(k < 10 ? 8'h3C : 8'hC3, k % 10)});
        end
        wait_idle(50);
        chk("b2b_frame_cnt", {28'd0, frame_cnt}, 32'd3);

        // 3: stall in IDLE, fill the FIFO, fifth byte waits for the first pop
        ser_two = 1'b1;
        push(8'h11, FRAME_BITS);
        push(8'h22, FRAME_BITS);
        push(8'h33, FRAME_BITS);
        push(8'h44, FRAME_BITS);
        @(negedge clk);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_busy", {31'd0, busy}, 32'd1);
        chk("full_line_idle", {31'd0, ser_one}, 32'd1);
        @(posedge clk);
        #1;
        fork
            push(8'h55, FRAME_BITS);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("stalled_in_ready", {31'd0, in_ready}, 32'd0);
                ser_two = 1'b0;
            end
        join
        wait_idle(200);
        chk("fill_frame_cnt", {28'd0, frame_cnt}, 32'd8);

        // 4: stall 3 cycles on data bit index 4 of F0 (a 0 bit)
        push(8'hF0, FRAME_BITS + 3);
        repeat (6) @(posedge clk);
        #1;
        ser_two = 1'b1;
        @(negedge clk);
        chk("stall_bit_level", {31'd0, ser_one}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        ser_two = 1'b0;
        wait_idle(50);
        chk("stall_frame_cnt", {28'd0, frame_cnt}, 32'd9);

        // 5: reset in the middle of a frame
        push(8'h00, FRAME_BITS);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_ser_one", {31'd0, ser_one}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_frame_cnt", {28'd0, frame_cnt}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_line", {31'd0, ser_one}, 32'd1);
        @(posedge clk);
        #1;

        // 6: 17 frames through a 4-bit counter; first one is the clean frame
        for (int i = 0; i < 17; i++) begin
            logic [7:0] b;
            b = 8'(i * 29 + 7);
            push(b, FRAME_BITS);
        end
        wait_idle(300);
        chk("wrap_frame_cnt", {28'd0, frame_cnt}, 32'd1);
        chk("all_frames_seen", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded limit");
        $fatal(1);
    end

endmodule

// File: doc/byte_line_serializer.md
Name: byte_line_serializer

Overview:
Upstream stage for my_module's `if1` port (modport `sys`: `one` input, `two` output).
- Accepts bytes on a valid/ready stream and buffers them in a small FIFO.
- Frames each byte onto the single-bit line `ser_one` (drives `if1.one`) as start / 8 data / stop.
- Honours a stall request on `ser_two` (driven from `if1.two`).
- Flat ports are used because modport `sys` gives the wrong direction for a driver.

Parameters:
- DEPTH, 4, byte FIFO depth; power of 2, ≥2.
- MSB_FIRST, 1, 1 = data bit 7 sent first, 0 = bit 0 first.
- CNT_W, 16, width of frame_cnt.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  8  byte to send (t_byte).
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO can accept; equals !full.
- ser_one  output  1  serial line, registered; idle level 1.
- ser_two  input  1  stall; 1 = hold current bit.
- busy  output  1  1 when FSM is not IDLE or FIFO is not empty.
- frame_cnt  output  CNT_W  frames completed, wraps.

Behaviour:
- Reset (async, immediate):
  - ser_one=1, state=IDLE, FIFO empty, bit_idx=0.
  - frame_cnt=0, busy=0, in_ready=1.
  - A frame in flight is aborted; the line returns high with no partial stop bit.
- Push:
  - Occurs at a rising edge when in_valid && in_ready.
  - When full, in_ready=0 even if a pop happens in the same cycle; no push-on-full.
- FSM states: IDLE, START, DATA, STOP. All transitions are gated by ser_two==0 at the edge; if ser_two==1, state, bit_idx and ser_one hold.
  - IDLE: ser_one=1. If FIFO non-empty: pop into shift reg, go to START.
  - START: ser_one=0 for one cycle, then DATA with bit_idx=0.
  - DATA: ser_one = current data bit (MSB or LSB per MSB_FIRST). Increment bit_idx; after 8 bits go to STOP.
  - STOP: ser_one=1 for one cycle. Then frame_cnt++. If FIFO non-empty, pop and go straight to START (back-to-back); else go to IDLE.
- Latency:
  - Byte pushed at edge t0 into an empty FIFO while IDLE: the start bit appears on ser_one from edge t1.
  - A frame is 10 cycles with no stall; no idle gap between back-to-back frames.
- Simultaneous push and pop on a non-full FIFO: both take effect; count is unchanged.
- Stall:
  - ser_two asserted in IDLE blocks the pop.
  - Stall during STOP delays the frame_cnt increment.
  - Stall has no effect on push.
- frame_cnt wraps from all-ones to 0 with no flag.
- FIFO pointers are log2(DEPTH)+1 bits wide; full/empty come from the MSB compare.

Decomposition:
- Package ser_pkg holds:
  - typedef logic[7:0] t_byte
  - enum t_ser_state {IDLE, START, DATA, STOP}
  - localparam IDLE_LEVEL=1'b1
  - localparam FRAME_BITS=10
- Sub-module sync_fifo #(DEPTH, type T=t_byte):
  - push/pop/full/empty interface, reset as above.
  - Instantiated once.
- FSM, shift register and counter live in the top.

Test Plan:
- Reset release, push 8'hA5 with MSB_FIRST=1, no stall -> ser_one from t1: 0,1,0,1,0,0,1,0,1,1; frame_cnt=1; busy=0 after 10 cycles.
- Push 8'h3C then 8'hC3 on consecutive cycles -> 20 contiguous bit cycles, no high gap; frame_cnt=2.
- DEPTH=4, hold ser_two=1, push 5 bytes -> in_ready drops after 4; 5th accepted only after ser_two=0 and first pop.
- Stall 3 cycles mid-DATA at bit_idx=4 of 8'hF0 -> that bit level held 4 cycles; frame takes 13 cycles total.
- Assert rst during DATA of 8'h00 -> ser_one=1 immediately, FIFO empty, frame_cnt unchanged at 0; next push sends a clean full frame.
- Preload frame_cnt path with CNT_W=4 and send 17 frames -> frame_cnt reads 1.
